// File: rtl/btn_debounce.sv
// -----------------------------------------------------------------------------
// btn_debounce
//
// Conditions raw board push-buttons before they reach the LED counter and
// Gray-code display logic. Each button has its own independent channel: a
// two-flop synchronizer followed by a counter-based debouncer. The outputs
// are a clean active-high level plus one-cycle press and release pulses.
//
// Optional feature macro: BTN_DEBOUNCE_AUTOREPEAT_EN
//   When defined, a held button re-pulses BTN_PRESS after 2^REPEAT_DELAY_LOG2
//   cycles and then every 2^REPEAT_RATE_LOG2 cycles until it is released.
//   When undefined, no hold timer exists and BTN_PRESS pulses once per press.
//
// Ports:
//   CLK          in   1     single clock, all state changes on rising edge
//   RST_N        in   1     asynchronous active-low reset
//   BTN_IN       in   NBTN  raw pins, asynchronous, polarity per ACTIVE_LOW
//   BTN_LEVEL    out  NBTN  debounced level, 1 = pressed, registered
//   BTN_PRESS    out  NBTN  one-cycle pulse per press (and autorepeat)
//   BTN_RELEASE  out  NBTN  one-cycle pulse per release
// -----------------------------------------------------------------------------
module btn_debounce #(
    parameter int              NBTN              = 4,
    parameter int              DEBOUNCE_LOG2     = 16,
    parameter logic [NBTN-1:0] ACTIVE_LOW        = 4'b1000,
    parameter int              REPEAT_DELAY_LOG2 = 23,
    parameter int              REPEAT_RATE_LOG2  = 21
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic [NBTN-1:0] BTN_IN,
    output logic [NBTN-1:0] BTN_LEVEL,
    output logic [NBTN-1:0] BTN_PRESS,
    output logic [NBTN-1:0] BTN_RELEASE
);

    // Terminal count: the input has disagreed with the level for
    // 2^DEBOUNCE_LOG2 consecutive edges when this value is seen.
    localparam logic [DEBOUNCE_LOG2-1:0] CNT_MAX = '1;

    // The repeat period has to fit inside the first-repeat delay because the
    // hold timer is only REPEAT_DELAY_LOG2+1 bits wide.
    if (REPEAT_RATE_LOG2 > REPEAT_DELAY_LOG2) begin : g_bad_repeat_cfg
        $error("btn_debounce: REPEAT_RATE_LOG2 must not exceed REPEAT_DELAY_LOG2");
    end

`ifdef BTN_DEBOUNCE_AUTOREPEAT_EN
    // The hold timer counts up to HOLD_FIRST for the first repeat, then
    // folds back to HOLD_BASE on every repeat so it never wraps and repeats
    // land every 2^REPEAT_RATE_LOG2 cycles after the first one.
    localparam logic [REPEAT_DELAY_LOG2:0] HOLD_BASE  = {1'b1, {REPEAT_DELAY_LOG2{1'b0}}};
    localparam logic [REPEAT_DELAY_LOG2:0] HOLD_FIRST = {1'b0, {REPEAT_DELAY_LOG2{1'b1}}};
    localparam logic [REPEAT_DELAY_LOG2:0] HOLD_NEXT  =
        HOLD_BASE | (REPEAT_DELAY_LOG2+1)'((1 << REPEAT_RATE_LOG2) - 1);
`endif

    for (genvar i = 0; i < NBTN; i++) begin : g_chan
        logic                     sync1;
        logic                     sync2;
        logic                     pressed;
        logic [DEBOUNCE_LOG2-1:0] cnt;
        logic                     level;
        logic                     press_pulse;
        logic                     release_pulse;
        logic                     settle;
        logic                     repeat_hit;

        // The synchronizer carries the raw pin value, so its reset value is
        // the released pin level and no false press appears after reset.
        always_ff @(posedge CLK or negedge RST_N) begin
            if (!RST_N) begin
                sync1 <= ACTIVE_LOW[i];
                sync2 <= ACTIVE_LOW[i];
            end else begin
                sync1 <= BTN_IN[i];
                sync2 <= sync1;
            end
        end

        // Normalised, synchronized input: 1 = pressed.
        assign pressed = sync2 ^ ACTIVE_LOW[i];

        // A new debounced level is accepted on the edge where the input has
        // been different from the level for the full debounce window.
        assign settle = (pressed != level) && (cnt == CNT_MAX);

`ifdef BTN_DEBOUNCE_AUTOREPEAT_EN
        logic [REPEAT_DELAY_LOG2:0] hold;

        // Repeats only while the level is held and never on the edge that
        // accepts a release.
        assign repeat_hit = level && !settle &&
                            ((hold == HOLD_FIRST) || (hold == HOLD_NEXT));

        // Hold timer: zero while released and on the press edge itself,
        // counting while the debounced level stays high.
        always_ff @(posedge CLK or negedge RST_N) begin
            if (!RST_N) begin
                hold <= '0;
            end else if (settle || !level) begin
                hold <= '0;
            end else if (repeat_hit) begin
                hold <= HOLD_BASE;
            end else begin
                hold <= hold + 1'b1;
            end
        end
`else
        assign repeat_hit = 1'b0;
`endif

        // Debounce counter and registered outputs. Any bounce back to the
        // current level restarts the window from zero.
        always_ff @(posedge CLK or negedge RST_N) begin
            if (!RST_N) begin
                cnt           <= '0;
                level         <= 1'b0;
                press_pulse   <= 1'b0;
                release_pulse <= 1'b0;
            end else begin
                press_pulse   <= (settle && pressed) || repeat_hit;
                release_pulse <= settle && !pressed;
                if (pressed == level) begin
                    cnt <= '0;
                end else if (cnt == CNT_MAX) begin
                    level <= pressed;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end

        assign BTN_LEVEL[i]   = level;
        assign BTN_PRESS[i]   = press_pulse;
        assign BTN_RELEASE[i] = release_pulse;
    end

endmodule

// File: tb/tb_btn_debounce.sv
// -----------------------------------------------------------------------------
// tb_btn_debounce
//
// Scoreboard bench for btn_debounce (DEBOUNCE_LOG2=3, REPEAT_DELAY_LOG2=5,
// REPEAT_RATE_LOG2=3). A reference model, evaluated on each rising edge,
// pushes every expected pulse event into a queue; a separate monitor pops
// and compares whenever the DUT shows a pulse or an expected event is due.
// Honours BTN_DEBOUNCE_AUTOREPEAT_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_btn_debounce;

    localparam int              NBTN  = 4;
    localparam int              DLOG  = 3;
    localparam int              RDLY  = 5;
    localparam int              RRATE = 3;
    localparam logic [NBTN-1:0] ALOW  = 4'b1000;
    localparam int              WIN   = 1 << DLOG;

    logic            CLK = 1'b0;
    logic            RST_N = 1'b0;
    logic [NBTN-1:0] BTN_IN = ALOW;
    logic [NBTN-1:0] BTN_LEVEL;
    logic [NBTN-1:0] BTN_PRESS;
    logic [NBTN-1:0] BTN_RELEASE;

    btn_debounce #(
        .NBTN              (NBTN),
        .DEBOUNCE_LOG2     (DLOG),
        .ACTIVE_LOW        (ALOW),
        .REPEAT_DELAY_LOG2 (RDLY),
        .REPEAT_RATE_LOG2  (RRATE)
    ) dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .BTN_IN      (BTN_IN),
        .BTN_LEVEL   (BTN_LEVEL),
        .BTN_PRESS   (BTN_PRESS),
        .BTN_RELEASE (BTN_RELEASE)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int              cyc;
        logic [NBTN-1:0] press;
        logic [NBTN-1:0] rel;
    } event_t;

    event_t          exp_q[$];
    int              checks = 0;
    int              failures = 0;
    int              edge_cnt = 0;
    logic [NBTN-1:0] model_level = '0;
    logic [NBTN-1:0] hist [0:WIN];
    int              press_edge [NBTN];

    // One comparison: counts it, and reports a mismatch on one line.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] required);
        checks++;
        if (actual !== required) begin
            failures++;
            $display("[TB] FAIL %s at edge %0d: got 0x%0h, expected 0x%0h",
                     name, edge_cnt, actual, required);
        end
    endtask

    // Reference model. hist[k] is the normalised pin sampled k+1 edges ago;
    // the value the debouncer sees at this edge is two edges old, so the
    // level flips when the last WIN such values (hist[1..WIN]) all differ
    // from the current level. Autorepeat fires at hold times 2^RDLY,
    // 2^RDLY + 2^RRATE, ... counted in edges from the press edge.
    task automatic modelStep();
        logic [NBTN-1:0] pin;
        logic [NBTN-1:0] ev_p;
        logic [NBTN-1:0] ev_r;
        event_t          ev;
        edge_cnt++;
        pin  = BTN_IN ^ ALOW;
        ev_p = '0;
        ev_r = '0;
        for (int ch = 0; ch < NBTN; ch++) begin
            int agree;
            agree = 0;
            for (int k = 1; k <= WIN; k++)
                if (hist[k][ch] == model_level[ch]) agree++;
            if (agree == 0) begin
                model_level[ch] = ~model_level[ch];
                if (model_level[ch]) begin
                    ev_p[ch]       = 1'b1;
                    press_edge[ch] = edge_cnt;
                end else begin
                    ev_r[ch] = 1'b1;
                end
            end
`ifdef BTN_DEBOUNCE_AUTOREPEAT_EN
            else if (model_level[ch]) begin
                int t;
                t = edge_cnt - press_edge[ch];
                if (t >= (1 << RDLY) && ((t - (1 << RDLY)) % (1 << RRATE)) == 0)
                    ev_p[ch] = 1'b1;
            end
`endif
        end
        for (int k = WIN; k >= 1; k--) hist[k] = hist[k-1];
        hist[0] = pin;
        if ((ev_p | ev_r) != '0) begin
            ev.cyc   = edge_cnt;
            ev.press = ev_p;
            ev.rel   = ev_r;
            exp_q.push_back(ev);
        end
    endtask

    // Model process: resets with the DUT, otherwise steps once per edge.
    initial begin
        for (int k = 0; k <= WIN; k++) hist[k] = '0;
        forever begin
            @(posedge CLK);
            if (!RST_N) begin
                for (int k = 0; k <= WIN; k++) hist[k] = '0;
                model_level = '0;
                exp_q.delete();
            end else begin
                modelStep();
            end
        end
    end

    // Monitor: samples 1 time unit after each rising edge.
    initial begin
        event_t ev;
        forever begin
            @(posedge CLK);
            #1;
            if (!RST_N) begin
                checkOutput("reset_outputs", {20'd0, BTN_LEVEL, BTN_PRESS, BTN_RELEASE}, '0);
            end else begin
                checkOutput("level", {28'd0, BTN_LEVEL}, {28'd0, model_level});
                if ((BTN_PRESS | BTN_RELEASE) != '0 ||
                    (exp_q.size() > 0 && exp_q[0].cyc <= edge_cnt)) begin
                    if (exp_q.size() == 0) begin
                        checkOutput("unexpected_pulse", {24'd0, BTN_PRESS, BTN_RELEASE}, '0);
                    end else begin
                        ev = exp_q.pop_front();
                        checkOutput("pulse_edge", edge_cnt, ev.cyc);
                        checkOutput("press", {28'd0, BTN_PRESS}, {28'd0, ev.press});
                        checkOutput("release", {28'd0, BTN_RELEASE}, {28'd0, ev.rel});
                    end
                end
            end
        end
    end

    // Drive a pin pattern at the falling edge and hold it for n rising edges.
    task automatic applyStimulus(input logic [NBTN-1:0] pins, input int n);
        @(negedge CLK);
        BTN_IN = pins;
        repeat (n) @(posedge CLK);
    endtask

    // Assert reset at a falling edge for n rising edges.
    task automatic applyReset(input int n);
        @(negedge CLK);
        RST_N = 1'b0;
        repeat (n) @(posedge CLK);
        @(negedge CLK);
        RST_N = 1'b1;
    endtask

    initial begin
        $display("[TB] start");
        // Reset with all pins released, then idle: nothing may happen.
        BTN_IN = ALOW;
        RST_N  = 1'b0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        RST_N = 1'b1;
        applyStimulus(ALOW, 50);

        // Active-low button 3 pressed and released.
        applyStimulus(4'b0000, 20);
        applyStimulus(ALOW, 20);

        // Exact latency on button 0, press then release.
        applyStimulus(4'b1001, 20);
        applyStimulus(ALOW, 20);

        // Bounce on button 1 (5 high, 2 low), then stable high.
        for (int r = 0; r < 6; r++) begin
            applyStimulus(4'b1010, 5);
            applyStimulus(ALOW, 2);
        end
        applyStimulus(4'b1010, 20);
        applyStimulus(ALOW, 20);

        // Simultaneous press on buttons 2..0.
        applyStimulus(4'b1111, 20);
        applyStimulus(ALOW, 20);

        // Same again with a one-edge reset at edge 6 of the press.
        applyStimulus(4'b1111, 5);
        applyReset(1);
        applyStimulus(4'b1111, 20);
        applyStimulus(ALOW, 20);

        // Long hold on button 0 (autorepeat window), then release.
        applyStimulus(4'b1001, 100);
        applyStimulus(ALOW, 20);

        // Randomised segments over all buttons, with one reset in the middle.
        for (int s = 0; s < 50; s++) begin
            applyStimulus(4'($urandom), $urandom_range(1, 14));
            if (s == 25) applyReset(2);
        end

        applyStimulus(ALOW, 30);
        checkOutput("queue_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/btn_debounce.md
Name: btn_debounce

Overview:
- Conditions the raw board push-buttons before they reach the LED counter/Gray-code display logic.
- Per button: two-flop synchronizer, then a counter-based debouncer.
- Produces:
  - clean active-high levels, which replace the raw button terms in the counter increment;
  - single-cycle press and release pulses for edge-driven consumers.
- One instance serves all board buttons. Each button has an independent per-button channel.

Parameters:
- NBTN, 4, number of button channels.
- DEBOUNCE_LOG2, 16, counter width; the input must be stable for 2^DEBOUNCE_LOG2 cycles before the output changes.
- ACTIVE_LOW, 4'b1000, per-bit polarity mask. A set bit means the pin is active-low. The default marks bit 3 (the BTN_N button) as active-low.
- REPEAT_DELAY_LOG2, 23, autorepeat first-repeat delay, 2^n cycles. Used only with the optional feature.
- REPEAT_RATE_LOG2, 21, autorepeat period, 2^n cycles. Used only with the optional feature.

Ports:
- CLK  input  1  single clock domain; all state changes on the rising edge.
- RST_N  input  1  asynchronous, active-low reset.
- BTN_IN  input  NBTN  raw pins, asynchronous to CLK, polarity given per bit by ACTIVE_LOW.
- BTN_LEVEL  output  NBTN  debounced level, active-high (1 = pressed), registered.
- BTN_PRESS  output  NBTN  one-cycle pulse on each debounced press (and on each autorepeat, if enabled), registered.
- BTN_RELEASE  output  NBTN  one-cycle pulse on each debounced release, registered.

Behaviour:
- Reset (RST_N low, asynchronous assert; deassert is sampled on CLK):
  - all outputs 0;
  - all counters 0;
  - synchronizer flops load the released level, i.e. the ACTIVE_LOW bit value, so no spurious press follows reset.
- Reset asserted mid-debounce or mid-hold aborts all activity; no pulse is emitted for the aborted event.
- Normalisation: p[i] = BTN_IN[i] ^ ACTIVE_LOW[i], so 1 = pressed.
- Synchronizer: s1 <= p; s2 <= s1. Only s2 is used downstream.
- Debounce, per channel, evaluated at each edge:
  - If s2 == BTN_LEVEL: cnt <= 0.
  - Else if cnt == 2^DEBOUNCE_LOG2-1: BTN_LEVEL <= s2; cnt <= 0; pulse on BTN_PRESS (if s2 = 1) or BTN_RELEASE (if s2 = 0) for exactly the next cycle.
  - Else: cnt <= cnt+1.
- Latency: a pin change that is setup before edge 1 and held stable changes BTN_LEVEL, and raises the matching pulse, after edge 2^DEBOUNCE_LOG2+2.
- Glitch filtering: any bounce that returns s2 to BTN_LEVEL clears cnt, so debouncing restarts from zero. Pulses shorter than 2^DEBOUNCE_LOG2 cycles produce no output activity.
- The counter is sized so it never wraps; the terminal value is handled explicitly.
- Channels are fully independent. Simultaneous events on several buttons assert several pulse bits in the same cycle.
- BTN_PRESS and BTN_RELEASE are never both high on the same bit in the same cycle.
- Pulses are never longer than one cycle.

Optional Feature:
- Macro: BTN_DEBOUNCE_AUTOREPEAT_EN.
- When defined:
  - A per-channel hold timer starts at 0 on the press edge.
  - While BTN_LEVEL[i] = 1, BTN_PRESS[i] re-pulses for one cycle at hold time 2^REPEAT_DELAY_LOG2, then every 2^REPEAT_RATE_LOG2 cycles after that.
  - The timer clears on release or reset.
  - No repeat pulse is emitted in the cycle a release is detected.
  - REPEAT_RATE_LOG2 must be ≤ REPEAT_DELAY_LOG2.
- When undefined:
  - No hold timer is generated.
  - BTN_PRESS pulses exactly once per press.
  - The repeat parameters are ignored.

Test Plan (DEBOUNCE_LOG2=3, REPEAT_DELAY_LOG2=5, REPEAT_RATE_LOG2=3 unless stated):
- Reset and polarity: hold RST_N low with BTN_IN=4'b1000, release reset, run 50 cycles -> BTN_LEVEL=0 throughout, no pulses. Drive BTN_IN[3]=0 -> BTN_LEVEL[3]=1 after edge 10, with a single BTN_PRESS[3] pulse.
- Exact latency: BTN_IN[0] 0->1 before edge 1, held -> BTN_LEVEL[0] rises and BTN_PRESS[0] is high for exactly 1 cycle after edge 10. Then drop BTN_IN[0] -> BTN_RELEASE[0] pulses 10 edges later.
- Bounce rejection: toggle BTN_IN[1] with high times of 5 cycles and low times of 2 cycles for 40 cycles, then hold high -> no output until 10 edges after the final stable rise, then one press pulse.
- Simultaneous and reset mid-operation: raise BTN_IN[2:0] on the same cycle -> BTN_PRESS=3'b111 together in one cycle. Repeat, asserting RST_N for 1 cycle at edge 6 -> no pulses. Outputs then follow the post-reset debounce, pressing again 10 edges after reset deassert if the pins are still pressed.
- Autorepeat (macro defined): hold BTN_IN[0] high for 80 cycles after debounce -> BTN_PRESS[0] pulses at hold times 0, 32, 40, 48, 56, 64, 72. On release -> only BTN_RELEASE[0] pulses, with no further press pulses.
- Macro undefined: same stimulus as the autorepeat scenario -> exactly one BTN_PRESS[0] pulse.
